// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: datapath width and RV32 load/store funct3 codes.
package load_store_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and word-memory signals between execute stage, load/store unit and data memory.
// Handshake: a request transfers on a rising clk edge where req_valid & req_ready are both high;
// the requester holds the request stable until then. resp_valid is a one-cycle pulse with no backpressure.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_is_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_address;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_load_data;
    logic            resp_fault;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_write_data;
    logic            mem_write_enable;
    logic            mem_read;
    logic [XLEN-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_address, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_load_data, resp_fault,
        output mem_address, mem_write_data, mem_write_enable, mem_read
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_address, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_load_data, resp_fault,
        input  mem_address, mem_write_data, mem_write_enable, mem_read
    );

endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: legality/alignment check, load extract+extend, store lane merge.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic [2:0]      i_funct3,
    input  logic            i_is_store,
    input  logic [1:0]      i_addr_lo,
    input  logic [15:0]     i_store_data,
    input  logic [XLEN-1:0] i_rdata,
    output logic            o_fault,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_merged
);

    logic       w_illegal;
    logic       w_misalign;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_illegal = 1'b0;
        case (i_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = i_is_store;
            default:          w_illegal = 1'b1;
        endcase
    end

    assign w_misalign = CHECK_ALIGN &&
                        ((((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr_lo[0]) ||
                         ((i_funct3 == F3_W) && (i_addr_lo != 2'b00)));
    assign o_fault = w_illegal | w_misalign;

    // Half lanes use addr[1] only, so with CHECK_ALIGN=0 addr[0] is simply ignored.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = i_rdata;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

    always_comb begin
        o_merged = i_rdata;
        if (i_funct3 == F3_B) begin
            o_merged[{i_addr_lo, 3'b000} +: 8] = i_store_data[7:0];
        end else if (i_funct3 == F3_H) begin
            if (i_addr_lo[1]) o_merged[31:16] = i_store_data;
            else              o_merged[15:0]  = i_store_data;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: maps RV32 B/H/W loads and stores onto a word-only memory,
// using read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    bus,
    output logic [1:0]          o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LD_WAIT  = 2'd1,
        S_RMW_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_addr;
    logic [2:0]      r_funct3;
    logic [15:0]     r_wdata;
    logic            r_is_store;
    logic            r_resp_valid;
    logic            r_resp_fault;
    logic [XLEN-1:0] r_resp_data;

    logic            w_idle;
    logic            w_accept;
    logic [XLEN-1:0] w_sel_addr;
    logic [2:0]      w_sel_funct3;
    logic [15:0]     w_sel_wdata;
    logic            w_sel_is_store;
    logic            w_fault;
    logic            w_is_sw;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_merged;

    assign w_idle        = (r_state == S_IDLE);
    assign bus.req_ready = w_idle & ~reset;
    assign w_accept      = bus.req_valid & bus.req_ready;

    // The single lane unit looks at the live request in IDLE and at the latched one while waiting.
    assign w_sel_addr     = w_idle ? bus.req_address     : r_addr;
    assign w_sel_funct3   = w_idle ? bus.req_funct3      : r_funct3;
    assign w_sel_wdata    = w_idle ? bus.req_wdata[15:0] : r_wdata;
    assign w_sel_is_store = w_idle ? bus.req_is_store    : r_is_store;

    lsu_align #(.CHECK_ALIGN(CHECK_ALIGN)) u_align (
        .i_funct3     (w_sel_funct3),
        .i_is_store   (w_sel_is_store),
        .i_addr_lo    (w_sel_addr[1:0]),
        .i_store_data (w_sel_wdata),
        .i_rdata      (bus.mem_read_data),
        .o_fault      (w_fault),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged)
    );

    assign w_is_sw = bus.req_is_store & (bus.req_funct3 == F3_W);

    assign bus.mem_address      = {w_sel_addr[XLEN-1:2], 2'b00};
    assign bus.mem_read         = ~reset & w_accept & ~w_fault & ~w_is_sw;
    assign bus.mem_write_enable = ~reset & ((w_accept & ~w_fault & w_is_sw) |
                                            (r_state == S_RMW_WAIT));
    assign bus.mem_write_data   = (r_state == S_RMW_WAIT) ? w_merged : bus.req_wdata;

    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_fault     = r_resp_fault;
    assign bus.resp_load_data = r_resp_data;
    assign o_dbg_state        = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_wdata      <= '0;
            r_is_store   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= bus.req_address;
                        r_funct3   <= bus.req_funct3;
                        r_wdata    <= bus.req_wdata[15:0];
                        r_is_store <= bus.req_is_store;
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                        end else if (!bus.req_is_store) begin
                            r_state <= S_LD_WAIT;
                        end else if (w_is_sw) begin
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= S_RMW_WAIT;
                        end
                    end
                end
                S_LD_WAIT: begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= w_load_data;
                    r_state      <= S_IDLE;
                end
                S_RMW_WAIT: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
